// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, bubble encoding and fetch FSM state type used
// by the fetch stage and its hold buffer.
//   PC_W     - program counter width (word addressed)
//   INSTR_W  - instruction word width
//   DATA_W   - datapath width (used by later stages)
//   REG_W    - register specifier width (used by later stages)
package pipeline_pkg;

  localparam int PC_W    = 15;
  localparam int INSTR_W = 20;
  localparam int DATA_W  = 19;
  localparam int REG_W   = 5;

  localparam logic [INSTR_W-1:0] NOP_ENC = 20'h00000;

  // FETCH: request outstanding; HOLD: word parked while StallF;
  // DISCARD: waiting for a stale request to drain after a redirect.
  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_HOLD    = 2'b01,
    ST_DISCARD = 2'b10
  } fetch_state_t;

  // PC increment, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 15'h0001;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry hold register for an instruction word and its
// PC, used when memory returns a word while the fetch stage is stalled.
//   clk, reset - clock, synchronous active-high reset
//   i_load     - capture i_instr / i_pc
//   i_drop     - invalidate the entry (wins over i_load)
//   o_valid    - entry holds a word; o_instr / o_pc are the held contents
module fetch_skid_buffer
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_drop,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;

  // Hold entry; a drop beats a load so a redirect never leaves a stale word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= {INSTR_W{1'b0}};
      r_pc    <= {PC_W{1'b0}};
    end else if (i_drop) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a ready/valid instruction memory port,
// stall/flush/redirect handling and the IF/ID pipeline register.
//   clk, reset               - clock, synchronous active-high reset
//   StallF, StallD, FlushD   - hazard unit controls
//   PCSrcE, PCTargetE        - redirect from execute
//   ImemReq, ImemAddr        - memory request (address held until transfer)
//   ImemReady, ImemRdata     - memory response, transfer = ImemReq & ImemReady
//   InstrD, PCD, PCPlus1D, ValidD - IF/ID register
//   FetchBusyF               - request waiting on memory this cycle
// Optional macro FETCH_PERF_CNT_EN adds saturating FetchCnt / StallCnt.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 15'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 20'h00000
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  output logic               ImemReq,
  output logic [PC_W-1:0]    ImemAddr,
  input  logic               ImemReady,
  input  logic [INSTR_W-1:0] ImemRdata,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus1D,
  output logic               ValidD,
  output logic               FetchBusyF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        FetchCnt,
  output logic [15:0]        StallCnt
`endif
);

  fetch_state_t       r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pcf, w_pcf_nxt;
  logic [PC_W-1:0]    r_pending, w_pending_nxt;
  logic               r_imem_req;
  logic               w_xfer;
  logic               w_deliver;
  logic [INSTR_W-1:0] w_dlv_instr;
  logic [PC_W-1:0]    w_dlv_pc;
  logic               w_skid_load, w_skid_drop, w_skid_valid;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [PC_W-1:0]    w_skid_pc;
  logic [INSTR_W-1:0] r_instr_d;
  logic [PC_W-1:0]    r_pc_d, r_pcp1_d;
  logic               r_valid_d;

  assign w_xfer = r_imem_req & ImemReady;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_drop  (w_skid_drop),
    .i_instr (ImemRdata),
    .i_pc    (r_pcf),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  // State, PC, pending target and request-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_pcf      <= RESET_PC;
      r_pending  <= {PC_W{1'b0}};
      r_imem_req <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_pcf      <= w_pcf_nxt;
      r_pending  <= w_pending_nxt;
      r_imem_req <= (w_state_nxt != ST_HOLD);
    end
  end

  // Next-state, PC update and delivery selection; redirect outranks stall.
  always_comb begin
    w_state_nxt   = r_state;
    w_pcf_nxt     = r_pcf;
    w_pending_nxt = r_pending;
    w_deliver     = 1'b0;
    w_dlv_instr   = ImemRdata;
    w_dlv_pc      = r_pcf;
    w_skid_load   = 1'b0;
    w_skid_drop   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (w_xfer) begin
          if (PCSrcE) begin
            w_pcf_nxt = PCTargetE;
          end else if (!StallF) begin
            w_deliver = 1'b1;
            w_pcf_nxt = pc_inc(r_pcf);
          end else begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else if (PCSrcE) begin
          // The address cannot change until memory answers, so park the target.
          w_pending_nxt = PCTargetE;
          w_state_nxt   = ST_DISCARD;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (PCSrcE) begin
          w_skid_drop = 1'b1;
          w_pcf_nxt   = PCTargetE;
          w_state_nxt = ST_FETCH;
        end else if (!StallF && w_skid_valid) begin
          w_deliver   = 1'b1;
          w_dlv_instr = w_skid_instr;
          w_dlv_pc    = w_skid_pc;
          w_skid_drop = 1'b1;
          w_pcf_nxt   = pc_inc(r_pcf);
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_DISCARD: begin
        if (PCSrcE) begin
          w_pending_nxt = PCTargetE;
        end else begin
          w_pending_nxt = r_pending;
        end
        if (w_xfer) begin
          // A redirect arriving on the draining beat is the newest target.
          w_pcf_nxt   = PCSrcE ? PCTargetE : r_pending;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_DISCARD;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
        w_pcf_nxt   = RESET_PC;
        w_skid_drop = 1'b1;
      end
    endcase
  end

  // IF/ID register: flush beats stall beats load; an empty load is a bubble.
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= {PC_W{1'b0}};
      r_pcp1_d  <= {PC_W{1'b0}};
      r_valid_d <= 1'b0;
    end else if (StallD) begin
      r_valid_d <= r_valid_d;
    end else if (w_deliver) begin
      r_instr_d <= w_dlv_instr;
      r_pc_d    <= w_dlv_pc;
      r_pcp1_d  <= pc_inc(w_dlv_pc);
      r_valid_d <= 1'b1;
    end else begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= {PC_W{1'b0}};
      r_pcp1_d  <= {PC_W{1'b0}};
      r_valid_d <= 1'b0;
    end
  end

  assign ImemReq    = r_imem_req;
  assign ImemAddr   = r_pcf;
  assign FetchBusyF = r_imem_req & ~ImemReady;
  assign InstrD     = r_instr_d;
  assign PCD        = r_pc_d;
  assign PCPlus1D   = r_pcp1_d;
  assign ValidD     = r_valid_d;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_cnt, r_stall_cnt;
  logic        w_real_load;

  assign w_real_load = !FlushD && !StallD && w_deliver;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= 16'h0000;
      r_stall_cnt <= 16'h0000;
    end else begin
      if (w_real_load && (r_fetch_cnt != 16'hFFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 16'h0001;
      end else begin
        r_fetch_cnt <= r_fetch_cnt;
      end
      if ((FetchBusyF || (r_state == ST_HOLD)) && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'h0001;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign FetchCnt = r_fetch_cnt;
  assign StallCnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run against a
// behavioural model of the fetch stage.
module tb_fetch_stage;

  logic        clk, reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [14:0] PCTargetE;
  logic        ImemReq;
  logic [14:0] ImemAddr;
  logic        ImemReady;
  logic [19:0] ImemRdata;
  logic [19:0] InstrD;
  logic [14:0] PCD, PCPlus1D;
  logic        ValidD, FetchBusyF;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] FetchCnt, StallCnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemReady(ImemReady), .ImemRdata(ImemRdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus1D(PCPlus1D),
    .ValidD(ValidD), .FetchBusyF(FetchBusyF)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCnt(FetchCnt), .StallCnt(StallCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Memory content: a distinct word per address.
  function automatic logic [19:0] mem_word(input logic [14:0] a);
    return {a[4:0] ^ 5'h15, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 15'h0000; ImemReady = 1'b0; ImemRdata = 20'h00000;
  endtask

  task automatic do_reset();
    clear_inputs();
    ImemReady = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    ImemReady = 1'b0;
  endtask

  task automatic run_fetches(input int n);
    for (int i = 0; i < n; i++) begin
      ImemReady = 1'b1;
      ImemRdata = mem_word(ImemAddr);
      tick();
    end
    ImemReady = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_held, m_drain, m_valid;
  logic [19:0] m_held_instr, m_instr;
  int          m_pcf, m_pending, m_pcd, m_pcp1;

  task automatic model_reset();
    m_held = 0; m_drain = 0; m_valid = 0;
    m_held_instr = 20'h00000; m_instr = 20'h00000;
    m_pcf = 0; m_pending = 0; m_pcd = 0; m_pcp1 = 0;
  endtask

  task automatic model_step();
    bit got, req, xfer;
    logic [19:0] gi;
    int gp;
    got = 0; gi = 20'h00000; gp = 0;
    req  = !m_held;
    xfer = req && ImemReady;
    if (m_held) begin
      if (PCSrcE) begin
        m_held = 0; m_pcf = int'(PCTargetE);
      end else if (!StallF) begin
        got = 1; gi = m_held_instr; gp = m_pcf;
        m_held = 0; m_pcf = (m_pcf + 1) % 32768;
      end
    end else if (m_drain) begin
      if (PCSrcE) m_pending = int'(PCTargetE);
      if (xfer) begin
        m_drain = 0; m_pcf = m_pending;
      end
    end else begin
      if (xfer) begin
        if (PCSrcE) m_pcf = int'(PCTargetE);
        else if (StallF) begin
          m_held = 1; m_held_instr = ImemRdata;
        end else begin
          got = 1; gi = ImemRdata; gp = m_pcf;
          m_pcf = (m_pcf + 1) % 32768;
        end
      end else if (PCSrcE) begin
        m_drain = 1; m_pending = int'(PCTargetE);
      end
    end
    if (FlushD || (!StallD && !got)) begin
      m_valid = 0; m_instr = 20'h00000; m_pcd = 0; m_pcp1 = 0;
    end else if (!StallD) begin
      m_valid = 1; m_instr = gi; m_pcd = gp; m_pcp1 = (gp + 1) % 32768;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (ImemReq !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b exp 1", ImemReq); end
    n_checks++; if (ImemAddr !== 15'h0000) begin n_fail++; $display("FAIL reset_addr: got %h exp 0000", ImemAddr); end
    n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", ValidD); end
    n_checks++; if (InstrD !== 20'h00000) begin n_fail++; $display("FAIL reset_instr: got %h exp 00000", InstrD); end
    n_checks++; if ({PCD, PCPlus1D} !== 30'h0) begin n_fail++; $display("FAIL reset_pcd: got %h/%h exp 0/0", PCD, PCPlus1D); end
    // Reset while a request at another address is still outstanding.
    PCSrcE = 1'b1; PCTargetE = 15'h0123; ImemReady = 1'b1; ImemRdata = mem_word(ImemAddr);
    tick();
    PCSrcE = 1'b0; ImemReady = 1'b0;
    tick();
    n_checks++; if (ImemAddr !== 15'h0123) begin n_fail++; $display("FAIL midreq_addr: got %h exp 0123", ImemAddr); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if ({ImemReq, ImemAddr} !== {1'b1, 15'h0000}) begin n_fail++; $display("FAIL midreq_reset: got %b/%h exp 1/0000", ImemReq, ImemAddr); end
  endtask

  task automatic test_basic();
    do_reset();
    ImemReady = 1'b1; ImemRdata = 20'h00011;
    tick();
    n_checks++; if ({ValidD, InstrD, PCD, PCPlus1D} !== {1'b1, 20'h00011, 15'h0000, 15'h0001}) begin
      n_fail++; $display("FAIL basic_first: got v=%b i=%h pc=%h p1=%h exp 1/00011/0000/0001", ValidD, InstrD, PCD, PCPlus1D); end
    ImemRdata = 20'h00022;
    tick();
    n_checks++; if ({ValidD, InstrD, PCD, ImemAddr} !== {1'b1, 20'h00022, 15'h0001, 15'h0002}) begin
      n_fail++; $display("FAIL basic_second: got v=%b i=%h pc=%h a=%h exp 1/00022/0001/0002", ValidD, InstrD, PCD, ImemAddr); end
    ImemReady = 1'b0;
  endtask

  task automatic test_wait_states();
    do_reset();
    run_fetches(5);
    for (int i = 0; i < 3; i++) begin
      ImemReady = 1'b0; ImemRdata = 20'hFFFFF;
      #1;
      n_checks++; if ({FetchBusyF, ImemAddr} !== {1'b1, 15'h0005}) begin
        n_fail++; $display("FAIL wait_busy%0d: got busy=%b a=%h exp 1/0005", i, FetchBusyF, ImemAddr); end
      tick();
      n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL wait_bubble%0d: got %b exp 0", i, ValidD); end
    end
    ImemReady = 1'b1; ImemRdata = mem_word(15'h0005);
    #1;
    n_checks++; if (FetchBusyF !== 1'b0) begin n_fail++; $display("FAIL wait_busy_end: got %b exp 0", FetchBusyF); end
    tick();
    n_checks++; if ({ValidD, InstrD, PCD} !== {1'b1, mem_word(15'h0005), 15'h0005}) begin
      n_fail++; $display("FAIL wait_instr: got v=%b i=%h pc=%h exp 1/%h/0005", ValidD, InstrD, PCD, mem_word(15'h0005)); end
    ImemReady = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    run_fetches(8);
    StallF = 1'b1; StallD = 1'b1; ImemReady = 1'b1; ImemRdata = mem_word(15'h0008);
    tick();
    n_checks++; if ({ImemReq, ImemAddr} !== {1'b0, 15'h0008}) begin
      n_fail++; $display("FAIL hold_enter: got req=%b a=%h exp 0/0008", ImemReq, ImemAddr); end
    ImemReady = 1'b0; ImemRdata = 20'hFFFFF;
    tick();
    n_checks++; if ({ImemReq, ValidD, PCD} !== {1'b0, 1'b1, 15'h0007}) begin
      n_fail++; $display("FAIL hold_stay: got req=%b v=%b pc=%h exp 0/1/0007", ImemReq, ValidD, PCD); end
    StallF = 1'b0; StallD = 1'b0;
    tick();
    n_checks++; if ({ValidD, InstrD, PCD, ImemAddr, ImemReq} !== {1'b1, mem_word(15'h0008), 15'h0008, 15'h0009, 1'b1}) begin
      n_fail++; $display("FAIL hold_release: got v=%b i=%h pc=%h a=%h req=%b exp 1/%h/0008/0009/1", ValidD, InstrD, PCD, ImemAddr, ImemReq, mem_word(15'h0008)); end
  endtask

  task automatic test_redirect();
    do_reset();
    run_fetches(12);
    ImemReady = 1'b0; PCSrcE = 1'b1; PCTargetE = 15'h0100;
    tick();
    n_checks++; if ({ImemReq, ImemAddr, ValidD} !== {1'b1, 15'h000C, 1'b0}) begin
      n_fail++; $display("FAIL redir_discard: got req=%b a=%h v=%b exp 1/000c/0", ImemReq, ImemAddr, ValidD); end
    PCSrcE = 1'b0;
    tick();
    ImemReady = 1'b1; ImemRdata = mem_word(15'h000C);
    tick();
    n_checks++; if ({ValidD, ImemAddr} !== {1'b0, 15'h0100}) begin
      n_fail++; $display("FAIL redir_drop: got v=%b a=%h exp 0/0100", ValidD, ImemAddr); end
    ImemRdata = mem_word(15'h0100);
    tick();
    n_checks++; if ({ValidD, InstrD, PCD} !== {1'b1, mem_word(15'h0100), 15'h0100}) begin
      n_fail++; $display("FAIL redir_target: got v=%b i=%h pc=%h exp 1/%h/0100", ValidD, InstrD, PCD, mem_word(15'h0100)); end
    ImemReady = 1'b0;
  endtask

  task automatic test_wrap_and_flush();
    do_reset();
    PCSrcE = 1'b1; PCTargetE = 15'h7FFF; ImemReady = 1'b1; ImemRdata = mem_word(15'h0000);
    tick();
    n_checks++; if ({ImemAddr, ValidD} !== {15'h7FFF, 1'b0}) begin
      n_fail++; $display("FAIL wrap_redir: got a=%h v=%b exp 7fff/0", ImemAddr, ValidD); end
    PCSrcE = 1'b0; ImemRdata = mem_word(15'h7FFF);
    tick();
    n_checks++; if ({ValidD, PCD, PCPlus1D, ImemAddr} !== {1'b1, 15'h7FFF, 15'h0000, 15'h0000}) begin
      n_fail++; $display("FAIL wrap_pc: got v=%b pc=%h p1=%h a=%h exp 1/7fff/0000/0000", ValidD, PCD, PCPlus1D, ImemAddr); end
    FlushD = 1'b1; StallD = 1'b1; StallF = 1'b1; ImemRdata = mem_word(15'h0000);
    tick();
    n_checks++; if ({ValidD, InstrD} !== {1'b0, 20'h00000}) begin
      n_fail++; $display("FAIL flush_stall: got v=%b i=%h exp 0/00000", ValidD, InstrD); end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 500; c++) begin
      n_checks++; if ({ImemReq, ImemAddr} !== {!m_held, 15'(m_pcf)}) begin
        n_fail++; $display("FAIL rnd_req c%0d: got %b/%h exp %b/%h", c, ImemReq, ImemAddr, !m_held, 15'(m_pcf)); end
      n_checks++; if ({ValidD, InstrD, PCD, PCPlus1D} !== {m_valid, m_instr, 15'(m_pcd), 15'(m_pcp1)}) begin
        n_fail++; $display("FAIL rnd_ifid c%0d: got %b/%h/%h/%h exp %b/%h/%h/%h", c, ValidD, InstrD, PCD, PCPlus1D,
                           m_valid, m_instr, 15'(m_pcd), 15'(m_pcp1)); end
      StallF = ($urandom_range(0, 4) == 0);
      StallD = StallF ? 1'b1 : ($urandom_range(0, 19) == 0);
      FlushD = ($urandom_range(0, 9) == 0);
      PCSrcE = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       PCTargetE = 15'h7FFE;
        1:       PCTargetE = 15'h7FFF;
        default: PCTargetE = 15'($urandom);
      endcase
      ImemReady = ($urandom_range(0, 9) < 7);
      ImemRdata = mem_word(ImemAddr);
      #1;
      n_checks++; if (FetchBusyF !== (!m_held && !ImemReady)) begin
        n_fail++; $display("FAIL rnd_busy c%0d: got %b exp %b", c, FetchBusyF, (!m_held && !ImemReady)); end
      model_step();
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_basic();
    test_wait_states();
    test_hold();
    test_redirect();
    test_wrap_and_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 15'h0000: PC loaded by reset.
REQ-002 Parameter NOP_INSTR, default 20'h00000: bubble encoding in InstrD.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 StallF  in  1  hazard unit: hold PCF, do not accept a new instruction.
REQ-006 StallD  in  1  hazard unit: hold IF/ID register.
REQ-007 FlushD  in  1  hazard unit: load bubble into IF/ID.
REQ-008 PCSrcE  in  1  taken branch/jump from execute: redirect.
REQ-009 PCTargetE  in  15  redirect target.
REQ-010 ImemReq  out  1  instruction memory request valid.
REQ-011 ImemAddr  out  15  request address (= PCF).
REQ-012 ImemReady  in  1  memory returns ImemRdata this cycle; transfer = ImemReq & ImemReady.
REQ-013 ImemRdata  in  20  instruction word.
REQ-014 InstrD  out  20  IF/ID instruction to decode.
REQ-015 PCD  out  15  IF/ID PC.
REQ-016 PCPlus1D  out  15  IF/ID PC+1.
REQ-017 ValidD  out  1  IF/ID holds a real instruction.
REQ-018 FetchBusyF  out  1  high in any cycle where ImemReq=1 and ImemReady=0.

Function
REQ-019 States: FETCH (request outstanding), HOLD (word buffered during StallF), DISCARD (drain stale request after redirect).
REQ-020 FETCH: ImemReq=1, ImemAddr=PCF; ImemAddr SHALL stay stable from first assertion until the transfer.
REQ-021 FETCH, transfer, !StallF, !PCSrcE: PCF<=PCF+1; word forwarded to IF/ID (if !StallD).
REQ-022 FETCH, transfer, StallF, !PCSrcE: word captured in hold buffer; next state HOLD; PCF unchanged.
REQ-023 HOLD: ImemReq=0; on !StallF, buffered word to IF/ID (if !StallD), PCF<=PCF+1, next FETCH.
REQ-024 FETCH, transfer, PCSrcE: returned word dropped; PCF<=PCTargetE; stay FETCH.
REQ-025 FETCH, no transfer, PCSrcE: PCTargetE latched as pending; next DISCARD.
REQ-026 DISCARD: ImemReq=1 at old address; on transfer, data dropped, PCF<=pending, next FETCH; a further PCSrcE in DISCARD overwrites pending.
REQ-027 HOLD, PCSrcE: buffered word dropped; PCF<=PCTargetE; next FETCH.
REQ-028 Priority: reset > PCSrcE > StallF; for IF/ID, reset > FlushD > StallD > load.
REQ-029 IF/ID load with no word delivered this cycle: bubble (InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus1D=0).
REQ-030 FlushD: bubble loaded regardless of StallD or delivery.
REQ-031 Latency: transfer with ImemReady in cycle N -> InstrD valid in cycle N+1.
REQ-032 PC arithmetic modulo 2^15: 15'h7FFF+1=15'h0000; PCPlus1D same rule.

Reset
REQ-033 On reset: PCF=RESET_PC, state FETCH, hold buffer empty, pending cleared, InstrD=NOP_INSTR, ValidD=0, PCD=0, PCPlus1D=0; ImemReq=1 on first cycle after reset.
REQ-034 Reset mid-request: outstanding transfer abandoned; memory SHALL accept address change on reset.

Configuration
REQ-035 Macro FETCH_PERF_CNT_EN defined: outputs FetchCnt[15:0] (increments per ValidD=1 load) and StallCnt[15:0] (increments per cycle with FetchBusyF or state HOLD), both saturating at 16'hFFFF, reset to 0.
REQ-036 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-037 Shared package pipeline_pkg: PC_W=15, INSTR_W=20, DATA_W=19, REG_W=5, NOP encoding, fetch state enum.
REQ-038 One sub-module fetch_skid_buffer: one-entry instruction/PC hold with valid, load, drop.

Verification
REQ-039 Reset, ImemReady=1 constant, words 20'h00011,20'h00022 -> InstrD 20'h00011 PCD 0, then 20'h00022 PCD 1, ValidD=1.
REQ-040 ImemReady low 3 cycles at PCF=5 -> ImemAddr=5 stable, FetchBusyF=1 three cycles, ValidD=0 bubbles, then instr@5.
REQ-041 StallF=StallD=1 as word at PCF=8 returns -> HOLD, ImemReq=0; release -> InstrD=word@8, PCF=9.
REQ-042 PCSrcE=1, PCTargetE=15'h0100 while request at 12 pending -> DISCARD, stale word dropped, next ImemAddr=15'h0100, no ValidD for 12.
REQ-043 PCF=15'h7FFF fetched -> PCPlus1D=0, next ImemAddr=0.
REQ-044 FlushD=1 with StallD=1 -> ValidD=0, InstrD=NOP_INSTR next cycle.
